// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
// Optional feature macro: PLL_SEQ_RELOCK_EN (see pll_reset_sequencer.sv).
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } pll_seq_state_t;

  localparam int DEF_RST_HOLD_CYCLES    = 32;
  localparam int DEF_LOCK_TIMEOUT       = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_SYS_RST_DELAY      = 16;
  localparam int DEF_MAX_RETRIES        = 7;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter only ever reaches (largest period - 1), so clog2 of the largest suffices.
  function automatic int seq_cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = max4(a, b, c, d);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int PLL_SEQ_CNT_W = seq_cnt_width(DEF_RST_HOLD_CYCLES, DEF_LOCK_TIMEOUT,
                                               DEF_LOCK_STABLE_CYCLES, DEF_SYS_RST_DELAY);

  function automatic logic pll_rst_of(input pll_seq_state_t s);
    return (s == RESET_PLL) || (s == FAULT);
  endfunction

  function automatic logic sys_rst_of(input pll_seq_state_t s);
    return (s != RUN);
  endfunction

  function automatic logic ready_of(input pll_seq_state_t s);
    return (s == RUN);
  endfunction

  function automatic logic fault_of(input pll_seq_state_t s);
    return (s == FAULT);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_chk.sv
// Output-consistency properties for the PLL reset sequencer.
module pll_reset_sequencer_chk #(
  parameter int MAX_RETRIES = 7,
  parameter int RC_W        = 3
) (
  input logic            clk,
  input logic            rst,
  input logic            pll_rst,
  input logic            sys_rst,
  input logic            ready,
  input logic            fault,
  input logic [RC_W-1:0] retry_count
);

  a_ready_clean : assert property (@(posedge clk) disable iff (rst)
    ready |-> (!sys_rst && !pll_rst && !fault));

  a_fault_held : assert property (@(posedge clk) disable iff (rst)
    fault |-> (pll_rst && sys_rst && !ready));

  a_sys_rst_ready : assert property (@(posedge clk) disable iff (rst)
    sys_rst == !ready);

  a_retry_bound : assert property (@(posedge clk) disable iff (rst)
    32'(retry_count) <= MAX_RETRIES);

endmodule

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, lock wait with timeout/retry, lock qualification and system reset release.
// Define PLL_SEQ_RELOCK_EN to re-run the whole sequence when lock drops in RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int SYS_RST_DELAY      = DEF_SYS_RST_DELAY,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic                             sys_rst,
  output logic                             ready,
  output logic                             fault,
  output logic                             lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

  localparam int CNT_W = seq_cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT,
                                       LOCK_STABLE_CYCLES, SYS_RST_DELAY);
  localparam int RC_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(SYS_RST_DELAY - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX    = RC_W'(MAX_RETRIES);

  pll_seq_state_t   state_r;
  pll_seq_state_t   state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             locked_s;
  logic             retry_inc_s;
  logic             lost_set_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state decision; loss of synchronized lock always has priority over count expiry.
  always_comb begin
    state_next_s = state_r;
    retry_inc_s  = 1'b0;
    lost_set_s   = 1'b0;
    case (state_r)
      RESET_PLL: begin
        if (cnt_r == HOLD_LAST) begin
          state_next_s = WAIT_LOCK;
        end else begin
          state_next_s = RESET_PLL;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next_s = STABILIZE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          if (retry_count == RETRY_MAX) begin
            state_next_s = FAULT;
          end else begin
            retry_inc_s  = 1'b1;
            state_next_s = RESET_PLL;
          end
        end else begin
          state_next_s = WAIT_LOCK;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_next_s = WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          state_next_s = RELEASE;
        end else begin
          state_next_s = STABILIZE;
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          state_next_s = WAIT_LOCK;
        end else if (cnt_r == DELAY_LAST) begin
          state_next_s = RUN;
        end else begin
          state_next_s = RELEASE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          lost_set_s = 1'b1;
`ifdef PLL_SEQ_RELOCK_EN
          state_next_s = RESET_PLL;
`else
          state_next_s = RUN;
`endif
        end else begin
          state_next_s = RUN;
        end
      end
      FAULT: begin
        state_next_s = FAULT;
      end
      default: begin
        state_next_s = RESET_PLL;
      end
    endcase
  end

  // State, shared counter and outputs decoded from next-state so they move with the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r     <= RESET_PLL;
      cnt_r       <= {CNT_W{1'b0}};
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= {RC_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (state_next_s != state_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      pll_rst   <= pll_rst_of(state_next_s);
      sys_rst   <= sys_rst_of(state_next_s);
      ready     <= ready_of(state_next_s);
      fault     <= fault_of(state_next_s);
      lock_lost <= lock_lost | lost_set_s;
      if (retry_inc_s) begin
        retry_count <= retry_count + RC_W'(1);
      end else begin
        retry_count <= retry_count;
      end
    end
  end

  pll_reset_sequencer_chk #(
    .MAX_RETRIES (MAX_RETRIES),
    .RC_W        (RC_W)
  ) u_chk (
    .clk         (refclk),
    .rst         (rst),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count)
  );

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scenarios plus randomized lock/reset traffic against a deadline-based reference model.
module tb_pll_reset_sequencer;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 8;
  localparam int DELAY   = 3;
  localparam int MAXR    = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready, fault, lock_lost;
  logic [1:0] retry_count;

  int errors = 0;
  int checks = 0;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES    (HOLD),
    .LOCK_TIMEOUT       (TIMEOUT),
    .LOCK_STABLE_CYCLES (STABLE),
    .SYS_RST_DELAY      (DELAY),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fault       (fault),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  // Reference model: phases with absolute deadlines instead of counters.
  localparam int P_HOLD = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3, P_RUN = 4, P_FAULT = 5;
  int m_phase = P_HOLD;
  int m_now = 0;
  int m_end = HOLD;
  int m_retries = 0;
  bit m_lost = 1'b0;
  bit m_h1 = 1'b0;
  bit m_h2 = 1'b0;

  task automatic model_step(input bit r, input bit p);
    bit seen;
    seen = m_h2;
    if (r) begin m_h1 = 1'b0; m_h2 = 1'b0; end
    else begin m_h2 = m_h1; m_h1 = p; end
    m_now++;
    if (r) begin
      m_phase = P_HOLD; m_end = m_now + HOLD; m_retries = 0; m_lost = 1'b0;
    end else begin
      case (m_phase)
        P_HOLD: if (m_now == m_end) begin m_phase = P_WAIT; m_end = m_now + TIMEOUT; end
        P_WAIT: begin
          if (seen) begin m_phase = P_STAB; m_end = m_now + STABLE; end
          else if (m_now == m_end) begin
            if (m_retries == MAXR) m_phase = P_FAULT;
            else begin m_retries++; m_phase = P_HOLD; m_end = m_now + HOLD; end
          end
        end
        P_STAB: begin
          if (!seen) begin m_phase = P_WAIT; m_end = m_now + TIMEOUT; end
          else if (m_now == m_end) begin m_phase = P_REL; m_end = m_now + DELAY; end
        end
        P_REL: begin
          if (!seen) begin m_phase = P_WAIT; m_end = m_now + TIMEOUT; end
          else if (m_now == m_end) m_phase = P_RUN;
        end
        P_RUN: if (!seen) begin
          m_lost = 1'b1;
`ifdef PLL_SEQ_RELOCK_EN
          m_phase = P_HOLD; m_end = m_now + HOLD;
`endif
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    v = 32'd0;
    v[6] = (m_phase == P_HOLD) || (m_phase == P_FAULT);
    v[5] = (m_phase != P_RUN);
    v[4] = (m_phase == P_RUN);
    v[3] = (m_phase == P_FAULT);
    v[2] = m_lost;
    v[1:0] = 2'(m_retries);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit r, input bit p);
    rst = r;
    pll_locked = p;
    @(posedge refclk);
    model_step(r, p);
    #1;
    check("model", 32'({pll_rst, sys_rst, ready, fault, lock_lost, retry_count}), model_vec());
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
    check({tag, "_retry"}, 32'(retry_count), 32'd0);
  endtask

  initial begin
    bit cur;
    int run_left;

    // Reset values
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check_reset("reset");

    // Normal lock: 4-cycle PLL reset pulse, then lock driven after the 10th cycle
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, 1'b0);
      check("pll_rst_pulse", 32'(pll_rst), 32'(i < 4));
    end
    for (int i = 1; i <= 14; i++) begin
      tick(1'b0, 1'b1);
      if (i >= 12) begin
        check("ready_edge", 32'(ready), 32'(i == 14));
        check("sys_rst_edge", 32'(sys_rst), 32'(i != 14));
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);

    // Loss of lock in RUN
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, 1'b0);
      if (i <= 3) check("lock_lost_delay", 32'(lock_lost), 32'(i == 3));
`ifdef PLL_SEQ_RELOCK_EN
      if (i >= 3) check("relock_pll_rst", 32'(pll_rst), 32'(i < 7));
      if (i == 3) check("relock_sys_rst", 32'(sys_rst), 32'd1);
`else
      check("loss_ready_held", 32'(ready), 32'd1);
`endif
    end

    // Chatter: one-cycle lock drop in the middle of STABILIZE
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      tick(1'b0, i != 7);
      if (i == 10) check("chatter_retry", 32'(retry_count), 32'd0);
      if (i == 14) check("chatter_no_early_ready", 32'(ready), 32'd0);
      if (i == 20) check("chatter_ready_pre", 32'(ready), 32'd0);
      if (i == 21) check("chatter_ready", 32'(ready), 32'd1);
    end

    // Reset asserted while in STABILIZE
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check_reset("rst_stab");

    // Lock never arrives: two retries, then FAULT
    for (int i = 1; i <= 80; i++) begin
      tick(1'b0, 1'b0);
      if (i == 23) begin
        check("to1_retry_pre", 32'(retry_count), 32'd0);
        check("to1_pll_rst_pre", 32'(pll_rst), 32'd0);
      end
      if (i == 24) begin
        check("to1_retry", 32'(retry_count), 32'd1);
        check("to1_pll_rst", 32'(pll_rst), 32'd1);
      end
      if (i == 28) check("to1_pulse_end", 32'(pll_rst), 32'd0);
      if (i == 48) check("to2_retry", 32'(retry_count), 32'd2);
      if (i == 71) check("fault_pre", 32'(fault), 32'd0);
      if (i == 72) begin
        check("fault", 32'(fault), 32'd1);
        check("fault_pll_rst", 32'(pll_rst), 32'd1);
        check("fault_sys_rst", 32'(sys_rst), 32'd1);
        check("fault_retry", 32'(retry_count), 32'd2);
      end
      if (i == 80) check("fault_sticky", 32'(fault), 32'd1);
    end

    // Reset asserted while in FAULT
    tick(1'b1, 1'b0);
    check_reset("rst_fault");

    // Randomized lock chatter with occasional resets
    cur = 1'b0;
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        cur = ~cur;
        run_left = cur ? $urandom_range(1, 60) : $urandom_range(1, 90);
      end
      run_left--;
      tick($urandom_range(0, 299) == 0, cur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
